// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg
// Shared types and sizes for the truth-table sweep controller.
//   sweep_state_t : sequencer states (idle, settle, sample, done)
//   N_VEC         : number of input vectors swept (all 3-bit combinations)
//   VEC_W         : width of the vector driven to the gate under test
//   MM_W          : width of the mismatch count (0..8 needs 4 bits)
package tt_sweep_pkg;

    localparam int N_VEC = 8;
    localparam int VEC_W = 3;
    localparam int MM_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } sweep_state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer
// Counts the cycles an input vector has been held so the sequencer knows
// when the gate output has had time to settle.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   clear    : force the count back to zero (has priority over count_en)
//   count_en : advance the count by one this cycle
//   expire   : high while the count equals SETTLE-1, i.e. in the last
//              settle cycle of the current vector
module tt_settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam logic [7:0] LAST_COUNT = 8'(SETTLE - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clearing wins so the sequencer can restart the settle
    // window for the next vector without any extra handshake.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register, zeroed by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == LAST_COUNT);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl
// Characterises a 3-input, 1-output combinational gate: drives all eight
// input vectors in turn, holds each for SETTLE cycles, samples the gate
// output, and reports the 8-bit truth-table signature, a pass flag and the
// number of bits that differ from EXPECTED.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : single-cycle sweep request, honoured only when idle
//   abort     : (only with TT_SWEEP_ABORT_EN) cancel a running sweep
//   dut_in    : vector {in1,in2,in3} driven to the gate, 0 when not sweeping
//   dut_out   : gate output
//   busy      : high while settling or sampling
//   done      : one-cycle pulse when signature/pass/mismatch are final
//   signature : bit i holds the gate output sampled for vector i
//   pass      : signature matched EXPECTED
//   mismatch  : number of signature bits differing from EXPECTED
// Configuration macro: TT_SWEEP_ABORT_EN adds the abort input.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int         SETTLE   = 4,
    parameter logic [7:0] EXPECTED = 8'h60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef TT_SWEEP_ABORT_EN
    input  logic             abort,
`endif
    output logic [VEC_W-1:0] dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] signature,
    output logic             pass,
    output logic [MM_W-1:0]  mismatch
);

    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(N_VEC - 1);

    sweep_state_t     state_q, state_d;
    logic [VEC_W-1:0] index_q, index_d;
    logic [N_VEC-1:0] signature_q, signature_d;
    logic             pass_q, pass_d;
    logic [MM_W-1:0]  mismatch_q, mismatch_d;

    logic             timer_clear;
    logic             timer_en;
    logic             settle_expire;
    logic             abort_hit;
    logic [N_VEC-1:0] sampled_sig;
    logic [MM_W-1:0]  sampled_pop;

`ifdef TT_SWEEP_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .count_en (timer_en),
        .expire   (settle_expire)
    );

    // The signature as it will look once the current sample is written.
    // Pass and mismatch are derived from this so that they are already
    // valid in the DONE cycle, alongside the done pulse.
    always_comb begin
        sampled_sig = signature_q;
        sampled_sig[index_q] = dut_out;
    end

    // Popcount of the differences between the completed signature and the
    // expected table.
    always_comb begin
        sampled_pop = '0;
        for (int i = 0; i < N_VEC; i++) begin
            sampled_pop = sampled_pop
                        + {{(MM_W-1){1'b0}}, sampled_sig[i] ^ EXPECTED[i]};
        end
    end

    // Sequencer next-state logic. The settle timer is held clear outside
    // SETTLE so every vector starts its settle window from zero. An abort
    // leaves the partial signature in place but drops pass/mismatch.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        signature_d = signature_q;
        pass_d      = pass_q;
        mismatch_d  = mismatch_q;
        timer_clear = 1'b1;
        timer_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    signature_d = '0;
                    pass_d      = 1'b0;
                    mismatch_d  = '0;
                    index_d     = '0;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                timer_clear = 1'b0;
                timer_en    = 1'b1;
                if (abort_hit) begin
                    pass_d     = 1'b0;
                    mismatch_d = '0;
                    state_d    = ST_IDLE;
                end else if (settle_expire) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort_hit) begin
                    pass_d     = 1'b0;
                    mismatch_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    signature_d = sampled_sig;
                    if (index_q == LAST_IDX) begin
                        pass_d     = (sampled_sig == EXPECTED);
                        mismatch_d = sampled_pop;
                        state_d    = ST_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            signature_q <= '0;
            pass_q      <= 1'b0;
            mismatch_q  <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            signature_q <= signature_d;
            pass_q      <= pass_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_DONE);
    assign dut_in    = busy ? index_q : '0;
    assign signature = signature_q;
    assign pass      = pass_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl
// Two sweep controllers share clock, reset and start: one with the default
// settle time (4) and expected table 8'h60, one with SETTLE=1 and expected
// table 8'hA5. Each drives its own behavioural gate (a lookup table). The
// reference model describes a sweep purely by cycle arithmetic from the
// cycle it was accepted, and pushes the expected results into a per-DUT
// queue that a negedge monitor pops whenever the DUT pulses done.
module tb_tt_sweep_ctrl;

    typedef struct {
        logic [7:0] sig;
        logic       pass;
        logic [3:0] mm;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
`ifdef TT_SWEEP_ABORT_EN
    logic       abort_s = 1'b0;
`endif
    logic [2:0] vin_w[2];
    logic       dout_w[2];
    logic       busy_w[2];
    logic       done_w[2];
    logic [7:0] sig_w[2];
    logic       pass_w[2];
    logic [3:0] mm_w[2];

    logic [7:0] tbl[2];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    int         act[2] = '{-1, -1};
    logic [7:0] held_sig[2] = '{8'h00, 8'h00};
    logic       held_pass[2] = '{1'b0, 1'b0};
    logic [3:0] held_mm[2] = '{4'h0, 4'h0};
    exp_t       sbq0[$];
    exp_t       sbq1[$];

    assign dout_w[0] = tbl[0][vin_w[0]];
    assign dout_w[1] = tbl[1][vin_w[1]];

    tt_sweep_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef TT_SWEEP_ABORT_EN
        .abort     (abort_s),
`endif
        .dut_in    (vin_w[0]),
        .dut_out   (dout_w[0]),
        .busy      (busy_w[0]),
        .done      (done_w[0]),
        .signature (sig_w[0]),
        .pass      (pass_w[0]),
        .mismatch  (mm_w[0])
    );

    tt_sweep_ctrl #(
        .SETTLE   (1),
        .EXPECTED (8'hA5)
    ) u_fast (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef TT_SWEEP_ABORT_EN
        .abort     (1'b0),
`endif
        .dut_in    (vin_w[1]),
        .dut_out   (dout_w[1]),
        .busy      (busy_w[1]),
        .done      (done_w[1]),
        .signature (sig_w[1]),
        .pass      (pass_w[1]),
        .mismatch  (mm_w[1])
    );

    // Free-running clock and cycle counter used by the timing model.
    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int settleOf(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] expOf(input int d);
        return (d == 0) ? 8'h60 : 8'hA5;
    endfunction

    // Where a sweep accepted so that its first busy cycle is a should be
    // in cycle c: each vector spans s+1 cycles, done follows the last one.
    function automatic void expAt(input int c, input int a, input int s,
                                  output logic b, output logic [2:0] v,
                                  output logic dn);
        int off;
        b  = 1'b0;
        v  = 3'd0;
        dn = 1'b0;
        if (a >= 0) begin
            off = c - a;
            if (off >= 0 && off < 8 * (s + 1)) begin
                b = 1'b1;
                v = 3'(off / (s + 1));
            end else if (off == 8 * (s + 1)) begin
                dn = 1'b1;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                     name, got, want, cyc);
        end
    endtask

    function automatic logic popItem(input int d, output exp_t it);
        it = '{sig: 8'h00, pass: 1'b0, mm: 4'h0, cyc: 0};
        if (d == 0) begin
            if (sbq0.size() == 0) return 1'b0;
            it = sbq0.pop_front();
        end else begin
            if (sbq1.size() == 0) return 1'b0;
            it = sbq1.pop_front();
        end
        return 1'b1;
    endfunction

    // Monitor: check every cycle against the model, pop the scoreboard on
    // done, then apply this cycle's start/abort to the model (the DUT sees
    // them at the coming rising edge).
    always @(negedge clk) begin
        exp_t       item;
        logic       eb;
        logic       ed;
        logic [2:0] ev;
        logic       got;
        int         s;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                act[d]       = -1;
                held_sig[d]  = 8'h00;
                held_pass[d] = 1'b0;
                held_mm[d]   = 4'h0;
            end
            sbq0.delete();
            sbq1.delete();
        end
        for (int d = 0; d < 2; d++) begin
            expAt(cyc, act[d], settleOf(d), eb, ev, ed);
            checkOutput($sformatf("busy%0d", d), 32'(busy_w[d]), 32'(eb));
            checkOutput($sformatf("dut_in%0d", d), 32'(vin_w[d]), 32'(ev));
            checkOutput($sformatf("done%0d", d), 32'(done_w[d]), 32'(ed));
            if (done_w[d]) begin
                got = popItem(d, item);
                checkOutput($sformatf("done_expected%0d", d), 32'(got), 32'd1);
                if (got) begin
                    checkOutput($sformatf("signature%0d", d), 32'(sig_w[d]), 32'(item.sig));
                    checkOutput($sformatf("pass%0d", d), 32'(pass_w[d]), 32'(item.pass));
                    checkOutput($sformatf("mismatch%0d", d), 32'(mm_w[d]), 32'(item.mm));
                    checkOutput($sformatf("done_cycle%0d", d), 32'(cyc), 32'(item.cyc));
                    held_sig[d]  = item.sig;
                    held_pass[d] = item.pass;
                    held_mm[d]   = item.mm;
                end
            end else if (!eb && !ed) begin
                checkOutput($sformatf("held_sig%0d", d), 32'(sig_w[d]), 32'(held_sig[d]));
                checkOutput($sformatf("held_pass%0d", d), 32'(pass_w[d]), 32'(held_pass[d]));
                checkOutput($sformatf("held_mm%0d", d), 32'(mm_w[d]), 32'(held_mm[d]));
            end else if (eb) begin
                checkOutput($sformatf("busy_pass%0d", d), 32'(pass_w[d]), 32'd0);
                checkOutput($sformatf("busy_mm%0d", d), 32'(mm_w[d]), 32'd0);
            end
        end
        if (!rst && start) begin
            for (int d = 0; d < 2; d++) begin
                s = settleOf(d);
                if (act[d] < 0 || cyc > act[d] + 8 * (s + 1)) begin
                    act[d]    = cyc + 1;
                    item.sig  = tbl[d];
                    item.pass = (tbl[d] == expOf(d));
                    item.mm   = 4'($countones(tbl[d] ^ expOf(d)));
                    item.cyc  = cyc + 1 + 8 * (s + 1);
                    if (d == 0) sbq0.push_back(item);
                    else        sbq1.push_back(item);
                    held_sig[d]  = 8'h00;
                    held_pass[d] = 1'b0;
                    held_mm[d]   = 4'h0;
                end
            end
        end
`ifdef TT_SWEEP_ABORT_EN
        if (!rst && abort_s) begin
            expAt(cyc, act[0], settleOf(0), eb, ev, ed);
            if (eb) begin
                s = settleOf(0);
                held_sig[0] = 8'h00;
                for (int v = 0; v < 8; v++) begin
                    if (act[0] + v * (s + 1) + s < cyc) held_sig[0][v] = tbl[0][v];
                end
                held_pass[0] = 1'b0;
                held_mm[0]   = 4'h0;
                act[0]       = -1;
                void'(sbq0.pop_back());
            end
        end
`endif
    end

    // Pulse start for one cycle, in cycle at_cyc or immediately if later.
    task automatic applyStimulus(input int at_cyc);
        int guard;
        guard = 0;
        @(posedge clk); #2;
        while (cyc < at_cyc && guard < 5000) begin
            @(posedge clk); #2;
            guard++;
        end
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

`ifdef TT_SWEEP_ABORT_EN
    task automatic pulseAbort(input int at_cyc);
        int guard;
        guard = 0;
        @(posedge clk); #2;
        while (cyc < at_cyc && guard < 5000) begin
            @(posedge clk); #2;
            guard++;
        end
        abort_s = 1'b1;
        @(posedge clk); #2;
        abort_s = 1'b0;
    endtask
`endif

    // Wait until both scoreboards have drained, with a cycle budget.
    task automatic waitIdle();
        int guard;
        guard = 0;
        while ((sbq0.size() != 0 || sbq1.size() != 0) && guard < 500) begin
            @(posedge clk); #2;
            guard++;
        end
        checkOutput("idle_timeout", 32'(guard >= 500), 32'd0);
    endtask

    // Assert reset mid-cycle and confirm the outputs clear without a clock.
    task automatic resetAt(input int at_cyc);
        int guard;
        guard = 0;
        @(posedge clk); #2;
        while (cyc < at_cyc && guard < 5000) begin
            @(posedge clk); #2;
            guard++;
        end
        rst = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy_w[0]), 32'd0);
        checkOutput("rst_dut_in", 32'(vin_w[0]), 32'd0);
        checkOutput("rst_done", 32'(done_w[0]), 32'd0);
        checkOutput("rst_signature", 32'(sig_w[0]), 32'd0);
        checkOutput("rst_pass", 32'(pass_w[0]), 32'd0);
        checkOutput("rst_mismatch", 32'(mm_w[0]), 32'd0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = 8'h60;
        tbl[1] = 8'(($urandom));
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] nominal sweep, gate high on vectors 5 and 6");
        applyStimulus(10);
        waitIdle();

        $display("[TB] constant-1 gate with ignored start pulses");
        tbl[0] = 8'hFF;
        tbl[1] = 8'hA5;
        applyStimulus(0);
        applyStimulus(act[0] + 3 * 5 + 1);
        applyStimulus(act[0] + 8 * 5);
        waitIdle();

        $display("[TB] reset during vector 4, then a fresh sweep");
        tbl[0] = 8'(($urandom));
        applyStimulus(0);
        resetAt(act[0] + 4 * 5 + 2);
        tbl[0] = 8'h60;
        tbl[1] = 8'h5A;
        applyStimulus(0);
        waitIdle();

`ifdef TT_SWEEP_ABORT_EN
        $display("[TB] abort during vector 2, abort while idle, then full sweep");
        tbl[0] = 8'h60;
        applyStimulus(0);
        pulseAbort(act[0] + 2 * 5 + 1);
        waitIdle();
        pulseAbort(0);
        applyStimulus(0);
        waitIdle();
`endif

        $display("[TB] randomised sweeps");
        for (int it = 0; it < 6; it++) begin
            tbl[0] = ($urandom_range(0, 2) == 0) ? 8'h60 : 8'(($urandom));
            tbl[1] = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'(($urandom));
            applyStimulus(cyc + 1 + int'($urandom_range(0, 3)));
            waitIdle();
        end

        repeat (3) @(posedge clk);
        checkOutput("sb_empty0", 32'(sbq0.size()), 32'd0);
        checkOutput("sb_empty1", 32'(sbq1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that characterises one 3-input, 1-output combinational logic gate by sweeping all eight input vectors, holding each for a programmable settle time, and sampling the gate output. It assembles the sampled 8-bit truth-table signature, compares it with an expected table, and reports pass/fail plus a mismatch count. It sits between the test/host control logic and the gate under test, driving the gate's three inputs and reading its single output.

## Interface
- `SETTLE`, default 4: cycles each input vector is held before sampling; legal range 1..255.
- `EXPECTED`, default 8'h60: expected signature; bit i = gate output for input vector i = {in1,in2,in3}.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a sweep.
- `dut_in`  out  3  vector driven to the gate, {in1,in2,in3}.
- `dut_out`  in  1  gate output.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when results become valid.
- `signature`  out  8  sampled truth table.
- `pass`  out  1  signature == EXPECTED.
- `mismatch`  out  4  popcount(signature ^ EXPECTED), 0..8.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `start`=1 → clear `signature`, `pass`, `mismatch`; index=0, settle count=0; → SETTLE. `start`=0 → stay.
- SETTLE: `dut_in`=index; count increments each cycle; at count==SETTLE-1 → SAMPLE.
- SAMPLE: `signature[index]` <= `dut_out`; `dut_in` still = index. If index==7 → DONE, else index+1, count=0 → SETTLE.
- DONE: register `pass` and `mismatch` from the complete signature; `done`=1 for this cycle only; → IDLE.
- `busy` = 1 in SETTLE and SAMPLE, 0 in IDLE and DONE.
- `dut_in` returns to 3'b000 in IDLE and DONE.
- `start` is ignored in SETTLE, SAMPLE and DONE (no queuing).
- `signature`, `pass`, `mismatch` hold their values from DONE until the next accepted `start`.
- Index is 3 bits; no wrap-around occurs because exit at index 7 is explicit.

## Timing
- Reset values: `dut_in`=0, `busy`=0, `done`=0, `signature`=0, `pass`=0, `mismatch`=0; state IDLE.
- `start` sampled at edge k → `busy` high from cycle k+1.
- Each vector occupies SETTLE+1 cycles (SETTLE settle + 1 sample).
- `done` high in cycle k + 8·(SETTLE+1) + 1; `pass`/`mismatch` valid in that same cycle.
- Reset mid-sweep: immediate return to reset values; partial signature discarded.
- Next `start` accepted no earlier than the cycle after `done`.

## Configuration
- `TT_SWEEP_ABORT_EN` defined: adds input `abort` (1 bit). `abort`=1 in SETTLE or SAMPLE → IDLE next cycle, `busy`=0, `done` not pulsed, `signature` holds the partial value, `pass`=0, `mismatch`=0. `abort` takes priority over the SAMPLE transition. `abort` has no effect in IDLE or DONE.
- Not defined: no `abort` port; a sweep always runs to completion or reset.

## Structure
- Package `tt_sweep_pkg`: state enum (IDLE, SETTLE, SAMPLE, DONE), `N_VEC`=8, `VEC_W`=3, `MM_W`=4.
- One sub-module, `tt_settle_timer`: load/clear, count, `expire` at SETTLE-1.
- Popcount stays inline in `tt_sweep_ctrl`.

## Test plan
- Reset, then gate model = output 1 on vectors 5,6; `start` at cycle 10, SETTLE=4 → `done` at cycle 51, `signature`=8'h60, `pass`=1, `mismatch`=0; `dut_in` steps 0..7, each held 5 cycles.
- Gate model = constant 1 → `signature`=8'hFF, `pass`=0, `mismatch`=6.
- `start` pulsed during SETTLE of vector 3 and again in the DONE cycle → both ignored; exactly one `done` pulse.
- Assert `rst` during vector 4 → all outputs 0 in the same cycle; a following `start` completes a fresh sweep with the correct signature.
- SETTLE=1 → `done` 17 cycles after `start`; each vector held 2 cycles.
- With `TT_SWEEP_ABORT_EN` defined: `abort` during vector 2 → `busy`=0 next cycle, no `done`, `pass`=0, `mismatch`=0; a subsequent full sweep gives `pass`=1.
